// File: rtl/counter_defs.sv
// Shared defaults and digit-field packing for the modulo-N cascade counter.
// Digit i of any packed count lives at [i*WIDTH +: WIDTH]; digit 0 is least significant.
package counter_defs;

  localparam int DEF_MODULUS = 10;
  localparam int DEF_DIGITS  = 2;
  localparam int DEF_WIDTH   = 4;

  function automatic int digit_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/counter_modn_digit.sv
// One modulo-MODULUS up/down digit with clamped parallel load.
// at_max/at_zero feed the ripple-enable chain of the digits above.
module counter_modn_digit #(
  parameter int MODULUS = 10,
  parameter int WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_digit,
  output logic [WIDTH-1:0] digit,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_digit;
  logic [WIDTH-1:0] w_load_clamped;

  // Out-of-range load fields saturate so the digit never leaves 0..MODULUS-1.
  assign w_load_clamped = (load_digit > MAX_VAL) ? MAX_VAL : load_digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit <= '0;
    end else if (load) begin
      r_digit <= w_load_clamped;
    end else if (step) begin
      if (up) begin
        r_digit <= at_max ? '0 : r_digit + WIDTH'(1);
      end else begin
        r_digit <= at_zero ? MAX_VAL : r_digit - WIDTH'(1);
      end
    end
  end

  assign digit   = r_digit;
  assign at_max  = (r_digit == MAX_VAL);
  assign at_zero = (r_digit == '0);

endmodule

// File: rtl/counter_modn_cascade.sv
// Cascade of DIGITS modulo-MODULUS up/down digits with load, terminal-count
// output and a sticky overflow flag; cout chains into the next instance's en.
module counter_modn_cascade
  import counter_defs::*;
#(
  parameter int MODULUS = DEF_MODULUS,
  parameter int DIGITS  = DEF_DIGITS,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] load_val,
  output logic [DIGITS*WIDTH-1:0] cnt,
  output logic                    cout,
  output logic                    ovf
);

  logic [DIGITS:0]   w_max_chain;
  logic [DIGITS:0]   w_zero_chain;
  logic [DIGITS-1:0] w_at_max;
  logic [DIGITS-1:0] w_at_zero;
  logic [DIGITS-1:0] w_step;
  logic              w_wrap;
  logic              r_ovf;

  // Chain bit i is set when every digit below i sits at its rollover value.
  assign w_max_chain[0]  = 1'b1;
  assign w_zero_chain[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam int LSB = digit_lsb(i, WIDTH);

    assign w_max_chain[i+1]  = w_max_chain[i] & w_at_max[i];
    assign w_zero_chain[i+1] = w_zero_chain[i] & w_at_zero[i];
    assign w_step[i]         = en & (up ? w_max_chain[i] : w_zero_chain[i]);

    counter_modn_digit #(
      .MODULUS (MODULUS),
      .WIDTH   (WIDTH)
    ) u_digit (
      .clk        (clk),
      .rst        (rst),
      .step       (w_step[i]),
      .up         (up),
      .load       (load),
      .load_digit (load_val[LSB +: WIDTH]),
      .digit      (cnt[LSB +: WIDTH]),
      .at_max     (w_at_max[i]),
      .at_zero    (w_at_zero[i])
    );
  end

  assign w_wrap = up ? w_max_chain[DIGITS] : w_zero_chain[DIGITS];
  assign cout   = en & w_wrap;

  // cout already includes en, so it marks exactly the edges where the whole count wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (load) begin
      r_ovf <= 1'b0;
    end else if (cout) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;

endmodule

// File: doc/counter_modn_cascade.md
# counter_modn_cascade

Parametrised cascade of modulo-N up/down digit counters: the general successor of the team's fixed decade counter. Counts DIGITS digits, each modulo MODULUS (default: two-digit decimal, 00–99). Adds count enable, direction control, synchronous parallel load, a terminal-count carry/borrow output and a sticky overflow flag. Used as the timebase/event counter behind display and timer blocks, and chained through `cout` for longer counts.

## Interface
- MODULUS, 10, count range per digit, 0..MODULUS-1; legal range ≥ 2.
- DIGITS, 2, number of cascaded digits; legal range ≥ 1.
- WIDTH, 4, bits per digit; must satisfy 2^WIDTH ≥ MODULUS.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; counts one step per enabled clock.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load.
- load_val  in  DIGITS*WIDTH  load value; digit i is bits [i*WIDTH +: WIDTH]; digit 0 is least significant.
- cnt  out  DIGITS*WIDTH  current count, packed the same way as load_val.
- cout  out  1  terminal count: carry when up=1, borrow when up=0.
- ovf  out  1  sticky wrap flag.

## Operation
- Priority on each rising edge of clk: rst > load > en. When en=0 and load=0, all state holds.
- rst=1: cnt ← 0 for all digits; ovf ← 0.
- load=1: each digit ← its load_val field. Field values ≥ MODULUS are clamped to MODULUS-1. ovf ← 0. en is ignored in the load cycle.
- Count up: digit 0 steps every enabled cycle. Digit i>0 steps only when all lower digits equal MODULUS-1. A digit at MODULUS-1 wraps to 0.
- Count down: a digit steps only when all lower digits equal 0. A digit at 0 wraps to MODULUS-1.
- cout = en & (up ? all digits == MODULUS-1 : all digits == 0).
  - Combinational from registered cnt and the live en/up inputs.
  - Feeds en of the next cascaded instance.
- ovf: set on the edge where the full count wraps (all digits roll over together) with en=1 and load=0. It stays set until rst or load.
- A change of up takes effect on the next edge. No dead cycle; the count never skips a value.
- Counter state never holds a digit value ≥ MODULUS.

## Timing
- Reset values: cnt = 0, ovf = 0. cout = en & ~up during reset, because cnt=0 satisfies the down terminal condition.
- cnt is registered with 1-cycle latency from en/load/rst to the new value.
- cout has zero latency: it is valid in the same cycle as the cnt value and en/up that produce it.
- ovf rises on the same edge as the wrapping cnt update.
- Asserting rst mid-count discards any simultaneous load or en.

## Structure
- Shared package/header `counter_defs` holds:
  - default MODULUS/DIGITS/WIDTH constants;
  - the digit-field indexing convention (digit i at [i*WIDTH +: WIDTH]).
- Sub-module `counter_modn_digit` implements one digit:
  - inputs: clk, rst, step, up, load, load_digit;
  - outputs: digit, at_max, at_zero;
  - performs the clamp and wrap for that digit.
- Top level:
  - generates DIGITS instances of counter_modn_digit;
  - builds the ripple-enable chain (digit i steps when en & all lower at_max/at_zero);
  - derives cout and the ovf register.

## Test plan
- Defaults; rst 2 cycles, then en=1, up=1 → cnt 0x00, 0x01…0x09, 0x10 at edge 10. At 0x99, cout=1. Next edge → cnt=0x00, ovf=1.
- After reset, en=1, up=0 → cout=1 at 0x00. Next edge → cnt=0x99, ovf=1. Next edge → 0x98, cout=0.
- load=1 with load_val=0x47 and en=1 in the same cycle → cnt=0x47, ovf cleared, no increment. Next enabled edge → 0x48.
- load_val=0x5C (digit 0 = 12) → cnt=0x59. load_val=0xF3 → cnt=0x93.
- Count up to 0x09 and set up=0 at that cycle → next edge cnt=0x08. Then en=0 for 5 cycles → cnt holds 0x08 and cout=0.
- At cnt=0x63, assert rst with load=1 and en=1 → cnt=0x00, ovf=0. With MODULUS=6, DIGITS=3, WIDTH=3, from 0 count 216 enabled edges → wraps to 0 with ovf=1.
